// File: rtl/arctan_arbiter.sv
// arctan_arbiter: lets NUM_REQ requesters share one pipelined arctan CORDIC core.
// Input side: round-robin grant, one transfer per cycle, registered into the core.
// Each accepted request pushes its requester index into a tag FIFO. Because the core
// returns results in order, the FIFO head always names the owner of the next result.
// A result that arrives while the FIFO is empty is an orphan and sets a sticky error.
module arctan_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = 1,
    parameter int DEPTH   = 32,
    parameter int CNT_W   = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [48*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   core_tvalid,
    output logic [47:0]            core_tdata,
    input  logic                   core_dout_tvalid,
    input  logic [23:0]            core_dout_tdata,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [23:0]            rsp_data,
    output logic [CNT_W-1:0]       outstanding,
    output logic                   err_orphan
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Requester slots are padded to a power of two so a TAG_W-bit index is always in range.
    localparam int SLOTS = 2 ** TAG_W;

    // ------------------------------------------------------------------
    // Requester slot unpacking
    // ------------------------------------------------------------------
    logic [SLOTS-1:0] valid_ext;
    logic [47:0]      req_slice [SLOTS];

    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
            if (gi < NUM_REQ) begin : g_live
                assign valid_ext[gi] = req_valid[gi];
                assign req_slice[gi] = req_data[48*gi +: 48];
            end else begin : g_pad
                assign valid_ext[gi] = 1'b0;
                assign req_slice[gi] = '0;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [TAG_W-1:0] rr_ptr_reg, rr_ptr_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             core_tvalid_reg, core_tvalid_next;
    logic [47:0]      core_tdata_reg, core_tdata_next;
    logic [NUM_REQ-1:0] rsp_valid_reg, rsp_valid_next;
    logic [23:0]      rsp_data_reg, rsp_data_next;
    logic             err_orphan_reg, err_orphan_next;

    // Tag store: tiny, and the head must be visible in the same cycle as the
    // returning result, so it is read combinationally.
    logic [TAG_W-1:0] tag_mem [DEPTH];
    logic [TAG_W-1:0] head_tag;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    // Requester index that is 'step' positions after 'base', modulo NUM_REQ.
    function automatic logic [TAG_W-1:0] rr_offset(input logic [TAG_W-1:0] base, input int step);
        int sum;
        sum = int'(base) + step;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return TAG_W'(sum);
    endfunction

    // FIFO pointer increment with wrap at DEPTH (DEPTH need not be a power of two).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [TAG_W-1:0] grant_idx;
    logic             grant_found;
    logic             fifo_room;
    logic             push;
    logic             pop;
    logic             orphan;

    // Round-robin search: first valid requester after the last winner.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int j = 1; j <= NUM_REQ; j++) begin
            if (!grant_found && valid_ext[rr_offset(rr_ptr_reg, j)]) begin
                grant_found = 1'b1;
                grant_idx   = rr_offset(rr_ptr_reg, j);
            end
        end
    end

    // Full check looks only at current occupancy; a same-cycle pop does not free a slot.
    assign fifo_room = (count_reg < CNT_W'(DEPTH));

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
            assign req_ready[gi] = grant_found && fifo_room && (grant_idx == TAG_W'(gi));
        end
    endgenerate

    assign push     = |(req_valid & req_ready);
    assign head_tag = tag_mem[rd_ptr_reg];
    assign pop      = core_dout_tvalid && (count_reg != '0);
    assign orphan   = core_dout_tvalid && (count_reg == '0);

    // ------------------------------------------------------------------
    // Response routing: one-hot pulse to the owner of the head tag
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
            assign rsp_valid_next[gi] = pop && (head_tag == TAG_W'(gi));
        end
    endgenerate

    // Next-state for pointers, occupancy, core input register and response data.
    always_comb begin
        rr_ptr_next      = rr_ptr_reg;
        wr_ptr_next      = wr_ptr_reg;
        rd_ptr_next      = rd_ptr_reg;
        count_next       = count_reg;
        core_tvalid_next = push;
        core_tdata_next  = core_tdata_reg;
        rsp_data_next    = rsp_data_reg;
        err_orphan_next  = err_orphan_reg | orphan;

        if (push) begin
            rr_ptr_next     = grant_idx;
            wr_ptr_next     = ptr_inc(wr_ptr_reg);
            core_tdata_next = req_slice[grant_idx];
        end
        if (pop) begin
            rd_ptr_next   = ptr_inc(rd_ptr_reg);
            rsp_data_next = core_dout_tdata;
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // Tag store write; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr_reg] <= grant_idx;
        end
    end

    // State registers; reset discards every in-flight tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg      <= TAG_W'(NUM_REQ - 1);
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            core_tvalid_reg <= 1'b0;
            core_tdata_reg  <= '0;
            rsp_valid_reg   <= '0;
            rsp_data_reg    <= '0;
            err_orphan_reg  <= 1'b0;
        end else begin
            rr_ptr_reg      <= rr_ptr_next;
            wr_ptr_reg      <= wr_ptr_next;
            rd_ptr_reg      <= rd_ptr_next;
            count_reg       <= count_next;
            core_tvalid_reg <= core_tvalid_next;
            core_tdata_reg  <= core_tdata_next;
            rsp_valid_reg   <= rsp_valid_next;
            rsp_data_reg    <= rsp_data_next;
            err_orphan_reg  <= err_orphan_next;
        end
    end

    assign core_tvalid = core_tvalid_reg;
    assign core_tdata  = core_tdata_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_data    = rsp_data_reg;
    assign outstanding = count_reg;
    assign err_orphan  = err_orphan_reg;

endmodule

// File: tb/tb_arctan_arbiter.sv
// Bench for arctan_arbiter: directed vectors, a small in-order core model with
// latency L, a queue-based reference model checked every cycle, and literal checks.
module tb_arctan_arbiter;

    localparam int N     = 2;
    localparam int TW    = 1;
    localparam int DEPTH = 4;
    localparam int CW    = 3;
    localparam int L     = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [48*N-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              core_tvalid;
    logic [47:0]       core_tdata;
    logic              core_dout_tvalid;
    logic [23:0]       core_dout_tdata;
    logic [N-1:0]      rsp_valid;
    logic [23:0]       rsp_data;
    logic [CW-1:0]     outstanding;
    logic              err_orphan;

    always #5 clk = ~clk;

    arctan_arbiter #(.NUM_REQ(N), .TAG_W(TW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_data         (req_data),
        .req_ready        (req_ready),
        .core_tvalid      (core_tvalid),
        .core_tdata       (core_tdata),
        .core_dout_tvalid (core_dout_tvalid),
        .core_dout_tdata  (core_dout_tdata),
        .rsp_valid        (rsp_valid),
        .rsp_data         (rsp_data),
        .outstanding      (outstanding),
        .err_orphan       (err_orphan)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Core model (in order, latency L) and stimulus driver
    // ------------------------------------------------------------------
    logic        hist_v [0:L];
    logic [23:0] hist_d [0:L];
    int          core_in_count = 0;
    logic        stall = 1'b0;
    int          cyc = 0;

    // Inputs change 2 time units after each rising edge. The core sees the
    // registered core_tvalid of this cycle and answers L cycles later with
    // 0x1234 + (sequence number of the accepted input).
    task automatic drive(input logic [N-1:0] v, input logic man, input logic [23:0] mdata);
        @(posedge clk);
        #2;
        cyc++;
        for (int i = L; i > 0; i--) begin
            hist_v[i] = hist_v[i-1];
            hist_d[i] = hist_d[i-1];
        end
        hist_v[0] = core_tvalid && !stall;
        hist_d[0] = 24'h001234 + 24'(core_in_count);
        if (hist_v[0]) core_in_count++;
        core_dout_tvalid = hist_v[L] | man;
        core_dout_tdata  = man ? mdata : hist_d[L];
        req_valid = v;
        for (int i = 0; i < N; i++) begin
            req_data[48*i +: 48] = {24'(cyc * 16 + i), 24'(cyc * 256 + i + 7)};
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: queue of owner indices plus expected registered outputs
    // ------------------------------------------------------------------
    int           m_q[$];
    int           m_last = N - 1;
    logic         m_ctv = 1'b0;
    logic [47:0]  m_ctd = '0;
    logic [N-1:0] m_rv = '0;
    logic [23:0]  m_rd = '0;
    logic         m_err = 1'b0;
    int           cmp_g;
    int           cmp_k;
    logic [N-1:0] cmp_ready;

    function automatic int pick();
        int c;
        if (m_q.size() >= DEPTH) return -1;
        for (int j = 1; j <= N; j++) begin
            c = (m_last + j) % N;
            if (((req_valid >> c) & 1) != 0) return c;
        end
        return -1;
    endfunction

    // Every falling edge: compare against the model, then advance it to what
    // the next rising edge must produce.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_ctrl", 64'({req_ready, core_tvalid, rsp_valid, outstanding, err_orphan}), 64'(0));
            chk("reset_tdata", 64'(core_tdata), 64'(0));
            chk("reset_rdata", 64'(rsp_data), 64'(0));
            m_q.delete();
            m_last = N - 1;
            m_ctv  = 1'b0;
            m_ctd  = '0;
            m_rv   = '0;
            m_rd   = '0;
            m_err  = 1'b0;
        end else begin
            cmp_g     = pick();
            cmp_ready = (cmp_g < 0) ? '0 : N'(1 << cmp_g);
            chk("req_ready", 64'(req_ready), 64'(cmp_ready));
            chk("core_tvalid", 64'(core_tvalid), 64'(m_ctv));
            chk("core_tdata", 64'(core_tdata), 64'(m_ctd));
            chk("rsp_valid", 64'(rsp_valid), 64'(m_rv));
            chk("rsp_data", 64'(rsp_data), 64'(m_rd));
            chk("outstanding", 64'(outstanding), 64'(m_q.size()));
            chk("err_orphan", 64'(err_orphan), 64'(m_err));
            // return path uses occupancy before this cycle's push
            m_rv = '0;
            if (core_dout_tvalid) begin
                if (m_q.size() > 0) begin
                    cmp_k = m_q.pop_front();
                    m_rv  = N'(1 << cmp_k);
                    m_rd  = core_dout_tdata;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (cmp_g >= 0) begin
                m_q.push_back(cmp_g);
                m_last = cmp_g;
                m_ctv  = 1'b1;
                m_ctd  = 48'(req_data >> (48 * cmp_g));
            end else begin
                m_ctv = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        rst_n            = 1'b0;
        req_valid        = '0;
        req_data         = '0;
        core_dout_tvalid = 1'b0;
        core_dout_tdata  = '0;
        for (int i = 0; i <= L; i++) begin
            hist_v[i] = 1'b0;
            hist_d[i] = '0;
        end

        drive(2'b00, 1'b0, 24'h0);
        #1 chk("lit_reset_state", 64'({req_ready, core_tvalid, rsp_valid, outstanding, err_orphan}), 64'(0));
        drive(2'b00, 1'b0, 24'h0);
        drive(2'b00, 1'b0, 24'h0);
        rst_n = 1'b1;
        drive(2'b00, 1'b0, 24'h0);

        // Single request from requester 0
        drive(2'b01, 1'b0, 24'h0);
        req_data[47:0] = {24'd0, 24'd1000};
        #1 chk("lit_single_ready", 64'(req_ready), 64'(2'b01));
        drive(2'b00, 1'b0, 24'h0);
        #1 chk("lit_single_tvalid", 64'(core_tvalid), 64'(1));
        chk("lit_single_tdata", 64'(core_tdata), 64'h0000000003E8);
        repeat (L) drive(2'b00, 1'b0, 24'h0);
        #1 chk("lit_single_early", 64'(rsp_valid), 64'(0));
        drive(2'b00, 1'b0, 24'h0);
        #1 chk("lit_single_rsp", 64'({rsp_valid, rsp_data}), 64'({2'b01, 24'h001234}));
        repeat (3) drive(2'b00, 1'b0, 24'h0);

        // Contention: requester 0 won last, so rotation starts at requester 1
        for (int i = 0; i < 8; i++) begin
            drive(2'b11, 1'b0, 24'h0);
            #1 chk("lit_rotate", 64'(req_ready), (i % 2 == 0) ? 64'(2'b10) : 64'(2'b01));
        end
        repeat (L + 4) drive(2'b00, 1'b0, 24'h0);

        // Full FIFO with the core stalled
        stall = 1'b1;
        repeat (4) drive(2'b01, 1'b0, 24'h0);
        drive(2'b01, 1'b0, 24'h0);
        #1 chk("lit_full_ready", 64'(req_ready), 64'(0));
        chk("lit_full_count", 64'(outstanding), 64'(4));
        drive(2'b01, 1'b1, 24'h0ABCDE);
        #1 chk("lit_full_no_grant_on_pop", 64'(req_ready), 64'(0));
        drive(2'b01, 1'b0, 24'h0);
        #1 chk("lit_full_rsp", 64'({rsp_valid, rsp_data}), 64'({2'b01, 24'h0ABCDE}));
        chk("lit_full_resume", 64'({req_ready, outstanding}), 64'({2'b01, 3'd3}));
        drive(2'b00, 1'b0, 24'h0);
        #1 chk("lit_full_refill", 64'(outstanding), 64'(4));
        for (int i = 0; i < 4; i++) drive(2'b00, 1'b1, 24'(24'h000100 + i));
        repeat (2) drive(2'b00, 1'b0, 24'h0);
        #1 chk("lit_drained", 64'(outstanding), 64'(0));

        // Simultaneous push and pop at occupancy 2
        drive(2'b10, 1'b0, 24'h0);
        drive(2'b01, 1'b0, 24'h0);
        drive(2'b10, 1'b1, 24'h000777);
        #1 chk("lit_simul_ready", 64'(req_ready), 64'(2'b10));
        drive(2'b00, 1'b0, 24'h0);
        #1 chk("lit_simul_count", 64'(outstanding), 64'(2));
        chk("lit_simul_rsp", 64'({rsp_valid, rsp_data}), 64'({2'b10, 24'h000777}));
        drive(2'b00, 1'b1, 24'h000888);
        drive(2'b00, 1'b1, 24'h000999);
        repeat (2) drive(2'b00, 1'b0, 24'h0);

        // Orphan result with an empty FIFO
        drive(2'b00, 1'b1, 24'h000555);
        drive(2'b00, 1'b0, 24'h0);
        #1 chk("lit_orphan", 64'({rsp_valid, err_orphan}), 64'({2'b00, 1'b1}));

        // Asynchronous reset with three results in flight
        stall = 1'b0;
        repeat (3) drive(2'b11, 1'b0, 24'h0);
        drive(2'b00, 1'b0, 24'h0);
        #1 chk("lit_inflight", 64'(outstanding), 64'(3));
        #1 rst_n = 1'b0;
        #1 chk("lit_async_ctrl", 64'({req_ready, core_tvalid, rsp_valid, outstanding, err_orphan}), 64'(0));
        chk("lit_async_data", 64'({core_tdata, rsp_data}), 64'(0));
        drive(2'b00, 1'b0, 24'h0);
        drive(2'b00, 1'b0, 24'h0);
        rst_n = 1'b1;
        repeat (6) drive(2'b00, 1'b0, 24'h0);
        #1 chk("lit_stale_orphan", 64'({rsp_valid, err_orphan}), 64'({2'b00, 1'b1}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
